dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit that sits between the CPU core's execute stage and the word-addressed `dmem`. It acts as the initiator on the `dmem` interface (CS, DM_W, DM_R, addr, wdata, rdata). It converts byte, halfword and word load/store requests into word accesses, and performs read-modify-write for sub-word stores. Misaligned accesses are detected and reported. The core waits on a busy/done handshake; `dmem` itself is only ever driven by this block.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: start request. Sampled only when `busy`=0.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `sign_ext` in 1: loads only; 1 = sign-extend the sub-word result, 0 = zero-extend.
- `addr` in 32: byte address.
- `wdata` in 32: store data, taken from the low bits according to `size`.
- `busy` out 1: high from the cycle after `req` is accepted through the done cycle.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: load result. Valid from the `done` cycle and held until the next load completes.
- `misalign` out 1: valid with `done`. High if the request was aborted.
- `CS`, `DM_W`, `DM_R` out 1 each: dmem controls.
- `mem_addr` out 32: dmem address. Always word-aligned ({addr[31:2],2'b00}).
- `mem_wdata` out 32: dmem write data.
- `mem_rdata` in 32: dmem read data. Combinational, valid in the same cycle as CS&DM_R.

## Operation
- States: IDLE, RD, WR, RESP.
- Capture: in IDLE with `req`=1, the block latches addr, size, we, sign_ext and wdata at the clock edge.
- Transition out of IDLE on an accepted request:
  - Misaligned access (half with addr[0]=1; word with addr[1:0]≠0): go to RESP with `misalign`=1. No dmem access.
  - Load: go to RD.
  - Word store: go to WR.
  - Byte or half store: go to RD.
- RD state:
  - Drives CS=1, DM_R=1, mem_addr.
  - `mem_rdata` is registered into the word buffer at the end of the cycle.
  - Next state: RESP for a load, WR for a store.
- WR state:
  - Drives CS=1, DM_W=1, mem_addr, mem_wdata.
  - Word store: mem_wdata = wdata.
  - Byte store: the buffered word with lane addr[1:0] (bits 8k+7:8k) replaced by wdata[7:0].
  - Half store: the buffered word with lane addr[1] (bits 16h+15:16h) replaced by wdata[15:0].
  - Next state: RESP.
- RESP state: `done`=1 for one cycle, then IDLE.
  - Load: `rdata` is updated at the RD→RESP edge with the extracted, extended lane.
  - Store or misaligned request: `rdata` is unchanged.
- Byte order is little-endian.
- Bus quiet rule: CS, DM_R and DM_W are 0 in IDLE and RESP. mem_addr and mem_wdata hold their last values.
- `req` while `busy`=1 is ignored (not queued).

## Timing
- Reset values: state IDLE; busy, done, misalign, CS, DM_R, DM_W = 0; rdata, mem_addr, mem_wdata, word buffer = 0.
- Cycle 0 is the edge where `req` is accepted. `done` is high in:
  - cycle 2 for a load;
  - cycle 2 for a word store;
  - cycle 3 for a sub-word store;
  - cycle 1 for a misaligned request.
- Exactly one DM_R cycle per load or sub-word store. Exactly one DM_W cycle per store. Never both in the same cycle.
- Back-to-back: a `req` in the cycle after `done` (state IDLE) is accepted.
- Reset mid-operation: state returns to IDLE at the reset edge and all outputs take their reset values the next cycle.
  - A WR cycle whose ending edge coincides with reset still writes, because dmem samples DM_W at that edge.
  - No partial RMW resumes after reset.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned requests are aborted as above, with `misalign`=1 and no dmem access.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - No misalign detection; `misalign` is tied to 0.
  - Low address bits are ignored: half uses addr[1] only, word ignores addr[1:0].
  - The access proceeds normally with the aligned-access latency.

## Test plan
- Preload word 0x40 = 0x1234F680:
  - lb 0x41 with sign_ext=1 → rdata 0xFFFFFFF6.
  - lbu 0x41 → 0x000000F6.
  - lh 0x42 with sign_ext=1 → 0x00001234.
  - Each gives `done` at cycle 2 with exactly one DM_R cycle.
- sb wdata 0x000000AB at 0x43 over 0x1234F680:
  - DM_R in cycle 1, DM_W in cycle 2 with mem_wdata 0xAB34F680, `done` in cycle 3.
  - A following lw 0x40 returns 0xAB34F680.
- sw 0xDEADBEEF at 0x44:
  - No DM_R cycle; DM_W in cycle 1; `done` in cycle 2.
  - A following lw 0x44 returns 0xDEADBEEF.
- lw 0x46:
  - With the macro: `done` and `misalign` in cycle 1, CS never asserted.
  - Without the macro: reads word 0x44, `misalign`=0.
- `req` pulses during `busy` → ignored. A `req` in the cycle after `done` → accepted; `done` returns 2 cycles later.
- Assert `reset` during RD of a load → next cycle state IDLE; busy, done, CS = 0; rdata = 0; no `done` pulse for the aborted request.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit between the execute stage and word-addressed dmem: byte/half/word
// access, read-modify-write for sub-word stores. Optional macro: LSU_MISALIGN_TRAP_EN.
module dmem_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        CS,
  output logic        DM_W,
  output logic        DM_R,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sext;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata_lo;
  logic        r_mis;
  logic [31:0] r_rdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_accept;
  logic        w_mis;
  logic [31:0] w_merge;
  logic [31:0] w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_accept = (r_state == S_IDLE) && req;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  // The fetched word is merged as it arrives, so the write-data register doubles as the RMW buffer.
  always_comb begin
    w_merge = mem_rdata;
    if (!r_size[1]) begin
      if (r_size[0]) w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata_lo;
      else           w_merge[{r_lane, 3'b000} +: 8]      = r_wdata_lo[7:0];
    end
  end

  always_comb begin
    w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
    w_half = mem_rdata[{r_lane[1], 4'b0000} +: 16];
    if (r_size[1])      w_load = mem_rdata;
    else if (r_size[0]) w_load = {{16{r_sext & w_half[15]}}, w_half};
    else                w_load = {{24{r_sext & w_byte[7]}}, w_byte};
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (w_mis)        w_next = S_RESP;
          else if (!we)     w_next = S_RD;
          else if (size[1]) w_next = S_WR;
          else              w_next = S_RD;
        end
      end
      S_RD:    w_next = r_we ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_RESP);
    misalign = (r_state == S_RESP) && r_mis;
    CS       = (r_state == S_RD) || (r_state == S_WR);
    DM_R     = (r_state == S_RD);
    DM_W     = (r_state == S_WR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_sext      <= 1'b0;
      r_lane      <= 2'b00;
      r_wdata_lo  <= 16'h0000;
      r_mis       <= 1'b0;
      r_rdata     <= 32'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
    end else begin
      if (w_accept) begin
        r_we       <= we;
        r_size     <= size;
        r_sext     <= sign_ext;
        r_lane     <= addr[1:0];
        r_wdata_lo <= wdata[15:0];
        r_mis      <= w_mis;
        if (!w_mis) r_mem_addr <= {addr[31:2], 2'b00};
        if (!w_mis && we && size[1]) r_mem_wdata <= wdata;
      end
      if (r_state == S_RD) begin
        if (r_we) r_mem_wdata <= w_merge;
        else      r_rdata     <= w_load;
      end
    end
  end

  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural word memory and an expectation queue
// popped at each done pulse.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        CS;
  logic        DM_W;
  logic        DM_R;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_val;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          cyc;
    int          nrd;
    int          nwr;
    logic [31:0] wword;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  dmem_lsu dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misalign(misalign), .CS(CS), .DM_W(DM_W), .DM_R(DM_R),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // dmem model: combinational read, write sampled at the clock edge
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (bd_we)             mem[bd_idx] <= bd_val;
    else if (CS && DM_W)   mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic m, input int c,
                              input int nr, input int nw, input logic [31:0] ww);
    exp_t e;
    e.rdata = r; e.mis = m; e.cyc = c; e.nrd = nr; e.nwr = nw; e.wword = ww;
    return e;
  endfunction

  task automatic op(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                    input logic [31:0] a, input logic [31:0] d, input exp_t e, input bit poke);
    int nrd = 0;
    int nwr = 0;
    int ncs = 0;
    int dcyc = -1;
    int both = 0;
    logic [31:0] ww = '0;
    logic mis_obs = 1'b0;
    exp_t x;
    sb_q.push_back(e);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (CS) ncs++;
      if (CS && DM_R) nrd++;
      if (CS && DM_W) begin nwr++; ww = mem_wdata; end
      if (DM_R && DM_W) both++;
      if (poke && c == 1) begin
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h0; wdata = 32'h55555555;
      end
      if (poke && c == 2) req = 1'b0;
      if (done) begin dcyc = c; mis_obs = misalign; break; end
    end
    req = 1'b0;
    x = sb_q.pop_front();
    chk({tag, ".done_cycle"}, 32'(dcyc), 32'(x.cyc));
    chk({tag, ".rdata"}, rdata, x.rdata);
    chk({tag, ".misalign"}, {31'd0, mis_obs}, {31'd0, x.mis});
    chk({tag, ".n_dm_r"}, 32'(nrd), 32'(x.nrd));
    chk({tag, ".n_dm_w"}, 32'(nwr), 32'(x.nwr));
    chk({tag, ".n_cs"}, 32'(ncs), 32'(x.nrd + x.nwr));
    chk({tag, ".rw_overlap"}, 32'(both), 32'd0);
    if (x.nwr > 0) chk({tag, ".mem_wdata"}, ww, x.wword);
  endtask

  initial begin
    int ndone;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; wdata = '0; bd_we = 1'b0; bd_idx = '0; bd_val = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_idx = 6'(i); bd_val = (i == 16) ? 32'h1234F680 : 32'h0;
    end
    @(negedge clk);
    bd_we = 1'b0;
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.cs", {31'd0, CS}, 32'd0);
    chk("reset.misalign", {31'd0, misalign}, 32'd0);
    chk("reset.rdata", rdata, 32'h0);
    chk("reset.mem_addr", mem_addr, 32'h0);
    reset = 1'b0;

    op("lb41",  1'b0, 2'b00, 1'b1, 32'h41, 32'h0, mk(32'hFFFFFFF6, 1'b0, 2, 1, 0, 32'h0), 1'b0);
    op("lbu41", 1'b0, 2'b00, 1'b0, 32'h41, 32'h0, mk(32'h000000F6, 1'b0, 2, 1, 0, 32'h0), 1'b0);
    op("lh42",  1'b0, 2'b01, 1'b1, 32'h42, 32'h0, mk(32'h00001234, 1'b0, 2, 1, 0, 32'h0), 1'b0);
    op("lh40",  1'b0, 2'b01, 1'b1, 32'h40, 32'h0, mk(32'hFFFFF680, 1'b0, 2, 1, 0, 32'h0), 1'b0);
    op("sb43",  1'b1, 2'b00, 1'b0, 32'h43, 32'h000000AB, mk(32'hFFFFF680, 1'b0, 3, 1, 1, 32'hAB34F680), 1'b0);
    op("lw40a", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, mk(32'hAB34F680, 1'b0, 2, 1, 0, 32'h0), 1'b0);
    op("sh40",  1'b1, 2'b01, 1'b0, 32'h40, 32'h9999CAFE, mk(32'hAB34F680, 1'b0, 3, 1, 1, 32'hAB34CAFE), 1'b0);
    op("lw40b", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, mk(32'hAB34CAFE, 1'b0, 2, 1, 0, 32'h0), 1'b0);
    op("sw44",  1'b1, 2'b10, 1'b0, 32'h44, 32'hDEADBEEF, mk(32'hAB34CAFE, 1'b0, 2, 0, 1, 32'hDEADBEEF), 1'b0);
    op("lw44",  1'b0, 2'b10, 1'b0, 32'h44, 32'h0, mk(32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0), 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    op("lw46",  1'b0, 2'b10, 1'b0, 32'h46, 32'h0, mk(32'hDEADBEEF, 1'b1, 1, 0, 0, 32'h0), 1'b0);
`else
    op("lw46",  1'b0, 2'b10, 1'b0, 32'h46, 32'h0, mk(32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0), 1'b0);
`endif
    op("lb47_poke", 1'b0, 2'b00, 1'b1, 32'h47, 32'h0, mk(32'hFFFFFFDE, 1'b0, 2, 1, 0, 32'h0), 1'b1);
    @(negedge clk);
    chk("poke.idle_after", {31'd0, busy}, 32'd0);
    chk("poke.mem0_untouched", mem[0], 32'h0);

    // reset lands while the load is in its RD cycle
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h40;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("rst_mid.in_rd", {31'd0, DM_R}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_mid.busy", {31'd0, busy}, 32'd0);
    chk("rst_mid.done", {31'd0, done}, 32'd0);
    chk("rst_mid.cs", {31'd0, CS}, 32'd0);
    chk("rst_mid.rdata", rdata, 32'h0);
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done || CS) ndone++;
    end
    chk("rst_mid.no_activity", 32'(ndone), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
